// File: rtl/can_error_frame_ctrl.sv
// CAN error-handling sequencer: merges detector error flags, maintains TEC/REC and
// the fault-confinement state, and sequences error flag / delimiter / bus-off recovery.
module can_error_frame_ctrl #(
  parameter int FLAG_LEN    = 6,
  parameter int DELIM_LEN   = 8,
  parameter int TEC_INC     = 8,
  parameter int PASSIVE_LIM = 128,
  parameter int BUSOFF_RUN  = 11,
  parameter int BUSOFF_SEQ  = 128
) (
  input  logic       SP,
  input  logic       reset,
  input  logic       RX,
  input  logic       TX_MODE,
  input  logic       BIT_Error,
  input  logic       STUFF_Error,
  input  logic       CRC_Error,
  input  logic       FORM_Error,
  input  logic       ACK_Error,
  input  logic       FRAME_OK,
  output logic       TX_BIT,
  output logic       ERR_FRAME,
  output logic [1:0] ERR_STATE,
  output logic [8:0] TEC,
  output logic [7:0] REC
);

  localparam int CNT_MAX = (FLAG_LEN > DELIM_LEN) ? FLAG_LEN : DELIM_LEN;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int RW = (BUSOFF_RUN > 1) ? $clog2(BUSOFF_RUN) : 1;
  localparam int SW = (BUSOFF_SEQ > 1) ? $clog2(BUSOFF_SEQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLAG,
    S_WAIT_DEL,
    S_DELIM,
    S_BUSOFF
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [RW-1:0] run, run_n;
  logic [SW-1:0] seq, seq_n;
  logic [8:0]    tec_n;
  logic [7:0]    rec_n;
  logic          flag_dom, dom_n;
  logic          any_err, take_err;
  logic [8:0]    tec_err;
  logic [7:0]    rec_err;
  logic          err_busoff, err_active;

  assign any_err = ~&{BIT_Error, STUFF_Error, CRC_Error, FORM_Error, ACK_Error};

  // Counter values as they would be after an error event this SP.
  assign tec_err    = TX_MODE ? TEC + 9'(TEC_INC) : TEC;
  assign rec_err    = (!TX_MODE && REC != 8'hFF) ? REC + 8'd1 : REC;
  assign err_busoff = tec_err > 9'd255;
  assign err_active = (tec_err < 9'(PASSIVE_LIM)) && ({1'b0, rec_err} < 9'(PASSIVE_LIM));

  always_ff @(posedge SP) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      run      <= '0;
      seq      <= '0;
      TEC      <= '0;
      REC      <= '0;
      flag_dom <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      run      <= run_n;
      seq      <= seq_n;
      TEC      <= tec_n;
      REC      <= rec_n;
      flag_dom <= dom_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    run_n    = run;
    seq_n    = seq;
    tec_n    = TEC;
    rec_n    = REC;
    dom_n    = flag_dom;
    take_err = 1'b0;

    case (state)
      S_IDLE: begin
        if (any_err) begin
          take_err = 1'b1;
        end else if (FRAME_OK) begin
          if (TX_MODE) begin
            if (TEC != '0) tec_n = TEC - 9'd1;
          end else begin
            if (REC != '0) rec_n = REC - 8'd1;
          end
        end
      end
      S_FLAG: begin
        if (cnt == CW'(FLAG_LEN)) begin
          state_n = S_WAIT_DEL;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_WAIT_DEL: begin
        if (RX) begin
          state_n = S_DELIM;
          cnt_n   = CW'(1);
        end
      end
      S_DELIM: begin
        // A dominant bit inside the delimiter is itself a form error.
        if (any_err || !RX) begin
          take_err = 1'b1;
        end else if (cnt == CW'(DELIM_LEN - 1)) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_BUSOFF: begin
        if (!RX) begin
          run_n = '0;
        end else if (run == RW'(BUSOFF_RUN - 1)) begin
          run_n = '0;
          if (seq == SW'(BUSOFF_SEQ - 1)) begin
            seq_n   = '0;
            tec_n   = '0;
            rec_n   = '0;
            state_n = S_IDLE;
          end else begin
            seq_n = seq + 1'b1;
          end
        end else begin
          run_n = run + 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase

    if (take_err) begin
      tec_n = tec_err;
      rec_n = rec_err;
      if (err_busoff) begin
        state_n = S_BUSOFF;
        cnt_n   = '0;
      end else begin
        state_n = S_FLAG;
        cnt_n   = CW'(1);
        dom_n   = err_active;
      end
    end
  end

  assign TX_BIT    = (state == S_FLAG) ? ~flag_dom : 1'b1;
  assign ERR_FRAME = (state == S_FLAG) || (state == S_WAIT_DEL) || (state == S_DELIM);
  assign ERR_STATE = TEC[8] ? 2'b10 :
                     ((TEC >= 9'(PASSIVE_LIM)) || ({1'b0, REC} >= 9'(PASSIVE_LIM))) ? 2'b01 : 2'b00;

endmodule

// File: tb/tb_can_error_frame_ctrl.sv
// Scoreboard bench for can_error_frame_ctrl: a behavioural model predicts every SP's
// outputs into a queue; an independent monitor compares them against the DUT.
module tb_can_error_frame_ctrl;

  logic       SP = 1'b0;
  logic       reset = 1'b1;
  logic       RX = 1'b1;
  logic       TX_MODE = 1'b0;
  logic       BIT_Error = 1'b1, STUFF_Error = 1'b1, CRC_Error = 1'b1;
  logic       FORM_Error = 1'b1, ACK_Error = 1'b1;
  logic       FRAME_OK = 1'b0;
  logic       TX_BIT, ERR_FRAME;
  logic [1:0] ERR_STATE;
  logic [8:0] TEC;
  logic [7:0] REC;

  can_error_frame_ctrl dut (
    .SP(SP), .reset(reset), .RX(RX), .TX_MODE(TX_MODE),
    .BIT_Error(BIT_Error), .STUFF_Error(STUFF_Error), .CRC_Error(CRC_Error),
    .FORM_Error(FORM_Error), .ACK_Error(ACK_Error), .FRAME_OK(FRAME_OK),
    .TX_BIT(TX_BIT), .ERR_FRAME(ERR_FRAME), .ERR_STATE(ERR_STATE),
    .TEC(TEC), .REC(REC)
  );

  always #5 SP = ~SP;

  typedef struct packed {
    logic       tx;
    logic       ef;
    logic [1:0] es;
    logic [8:0] tec;
    logic [7:0] rec;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   passed = 0;

  // Reference model: counts flag bits remaining down, delimiter bits seen up,
  // and bus-off recovery as runs/sequences of recessive bits.
  int m_tec = 0, m_rec = 0, m_flags_left = 0, m_delim = 0, m_brun = 0, m_bseq = 0;
  bit m_wait = 0, m_busoff = 0, m_dom = 0;

  task automatic model_step(bit rst, bit rx, bit txm, logic [4:0] errs, bit fok);
    bit ev = 0;
    bit flagged = (errs != 5'h1f);
    if (rst) begin
      m_tec = 0; m_rec = 0; m_flags_left = 0; m_delim = 0; m_brun = 0; m_bseq = 0;
      m_wait = 0; m_busoff = 0; m_dom = 0;
      return;
    end
    if (m_busoff) begin
      if (rx) begin
        m_brun++;
        if (m_brun == 11) begin
          m_brun = 0;
          m_bseq++;
          if (m_bseq == 128) begin
            m_bseq = 0; m_tec = 0; m_rec = 0; m_busoff = 0;
          end
        end
      end else begin
        m_brun = 0;
      end
    end else if (m_flags_left > 0) begin
      m_flags_left--;
      if (m_flags_left == 0) m_wait = 1;
    end else if (m_wait) begin
      if (rx) begin
        m_wait = 0;
        m_delim = 1;
      end
    end else if (m_delim > 0) begin
      if (flagged || !rx) ev = 1;
      else begin
        m_delim++;
        if (m_delim == 8) m_delim = 0;
      end
    end else begin
      if (flagged) ev = 1;
      else if (fok) begin
        if (txm) m_tec = (m_tec > 0) ? m_tec - 1 : 0;
        else     m_rec = (m_rec > 0) ? m_rec - 1 : 0;
      end
    end
    if (ev) begin
      m_delim = 0;
      if (txm) m_tec += 8;
      else if (m_rec < 255) m_rec++;
      if (m_tec > 255) m_busoff = 1;
      else begin
        m_flags_left = 6;
        m_dom = (m_tec < 128) && (m_rec < 128);
      end
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.tx  = (m_flags_left > 0) ? !m_dom : 1'b1;
    e.ef  = (m_flags_left > 0) || m_wait || (m_delim > 0);
    e.es  = (m_tec > 255) ? 2'b10 : ((m_tec >= 128 || m_rec >= 128) ? 2'b01 : 2'b00);
    e.tec = 9'(m_tec);
    e.rec = 8'(m_rec);
    return e;
  endfunction

  // errs bit order: {BIT, STUFF, CRC, FORM, ACK}, active low.
  task automatic drive(bit rst, bit rx, bit txm, logic [4:0] errs, bit fok);
    @(negedge SP);
    reset = rst;
    RX = rx;
    TX_MODE = txm;
    {BIT_Error, STUFF_Error, CRC_Error, FORM_Error, ACK_Error} = errs;
    FRAME_OK = fok;
    model_step(rst, rx, txm, errs, fok);
    expq.push_back(model_out());
  endtask

  task automatic idle(int n, bit txm);
    repeat (n) drive(1'b0, 1'b1, txm, 5'h1f, 1'b0);
  endtask

  initial begin
    exp_t e, got;
    forever begin
      @(posedge SP);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        got = {TX_BIT, ERR_FRAME, ERR_STATE, TEC, REC};
        checks++;
        if (got === e) passed++;
        else $display("FAIL sp_outputs t=%0t got tx=%b ef=%b es=%b tec=%0d rec=%0d required tx=%b ef=%b es=%b tec=%0d rec=%0d",
                      $time, got.tx, got.ef, got.es, got.tec, got.rec, e.tx, e.ef, e.es, e.tec, e.rec);
      end
    end
  end

  initial begin
    int ep, rxp, txsel;
    bit txm;
    logic [4:0] errs;

    repeat (3) drive(1'b1, 1'b1, 1'b0, 5'h1f, 1'b0);

    // Active receiver CRC error, full flag + delimiter
    drive(1'b0, 1'b1, 1'b0, 5'b11011, 1'b0);
    idle(20, 1'b0);

    // Superposed flags hold the delimiter wait
    drive(1'b0, 1'b1, 1'b0, 5'b01111, 1'b0);
    idle(6, 1'b0);
    repeat (5) drive(1'b0, 1'b0, 1'b0, 5'h1f, 1'b0);
    idle(15, 1'b0);

    // Form error at delimiter bit 4
    drive(1'b0, 1'b1, 1'b0, 5'b11101, 1'b0);
    idle(6, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 5'h1f, 1'b0);
    idle(2, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 5'h1f, 1'b0);
    idle(20, 1'b0);

    // Decrements via FRAME_OK, floor at zero
    repeat (5) drive(1'b0, 1'b1, 1'b0, 5'h1f, 1'b1);

    // Simultaneous flags with FRAME_OK, then reset during flag bit 3
    drive(1'b0, 1'b1, 1'b0, 5'b11100, 1'b1);
    idle(2, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 5'h1f, 1'b0);
    idle(5, 1'b0);

    // Transmitter errors through passive into bus-off
    repeat (31) begin
      drive(1'b0, 1'b1, 1'b1, 5'b01111, 1'b0);
      idle(15, 1'b1);
    end
    drive(1'b0, 1'b1, 1'b1, 5'b11110, 1'b0);
    // Run broken at run = 10, then exactly 1408 recessive bits to recover
    idle(10, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 5'h1f, 1'b0);
    idle(1407, 1'b1);
    idle(1, 1'b1);
    idle(5, 1'b1);

    // Randomized segments
    for (int seg = 0; seg < 8; seg++) begin
      case (seg % 4)
        0: begin ep = 5;  rxp = 5;  txsel = 2; end
        1: begin ep = 30; rxp = 5;  txsel = 1; end
        2: begin ep = 0;  rxp = 0;  txsel = 1; end
        default: begin ep = 15; rxp = 20; txsel = 0; end
      endcase
      for (int i = 0; i < 1500; i++) begin
        txm  = (txsel == 2) ? bit'($urandom_range(0, 1)) : bit'(txsel);
        errs = ($urandom_range(0, 99) < ep) ? 5'($urandom_range(0, 30)) : 5'h1f;
        drive(($urandom_range(0, 1999) == 0), ($urandom_range(0, 99) >= rxp), txm,
              errs, ($urandom_range(0, 9) == 0));
      end
    end

    idle(2, 1'b0);
    repeat (3) @(posedge SP);
    #2;
    checks++;
    if (expq.size() == 0) passed++;
    else $display("FAIL queue_drain pending=%0d required=0", expq.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
